credit_tx: RTL and testbench
============================

# credit_tx

Transmit end of a credit-based link that feeds a remote `pipeline_fifo` when a combinational ready cannot cross the path because of wire or pipeline latency. It accepts words from a local valid/ready producer and launches them as a registered, ready-less valid/data stream. It also keeps a credit count that mirrors the free slots in the remote FIFO, and the receiver returns one credit per pop. The block sits at the boundary of the sending partition, and its only link-side inputs are the credit-return pulse and an init.

## Interface
Reset: one clock domain. The reset is synchronous and active-low on `arst_n`: it is sampled only on the rising edge of `clk`.

Parameters:
- `ELEM_WIDTH`, 32: data word width.
- `CREDITS`, 5: initial and maximum credits. This must equal the remote FIFO depth. Legal values are 1 and up.
- `CNT_W`, `$clog2(CREDITS+1)`: credit counter width. This is derived and must not be overridden.

Ports:
- `clk` in 1: clock.
- `arst_n` in 1: synchronous active-low reset.
- `init` in 1: synchronous re-initialisation with the same effect as reset. It takes priority over all other inputs in that cycle.
- `data_in` in `ELEM_WIDTH`: upstream data.
- `data_in_val` in 1: upstream valid.
- `data_in_rdy` out 1: upstream ready, equal to `credit_cnt != 0`. It is decoded from registers only and has no combinational path from `data_in_val`.
- `tx_data` out `ELEM_WIDTH`: link data, registered.
- `tx_val` out 1: link valid, registered. The receiver must accept the word unconditionally.
- `credit_ret` in 1: one credit returned per cycle in which it is high.
- `credit_cnt` out `CNT_W`: current credits, registered.
- `credit_err` out 1: sticky credit-overflow flag.
- `idle` out 1: high when `credit_cnt == CREDITS`, `tx_val == 0` and `credit_err == 0`.

## Operation
Send rule:
- `send = data_in_val && data_in_rdy`.
- On `send`, the next cycle has `tx_val = 1` and `tx_data` equal to the captured `data_in`.
- With no `send`, the next cycle has `tx_val = 0` and `tx_data` holds its last value. Downstream must not qualify data without valid.

Credit update:
- The next count is `credit_cnt - send + credit_ret`, evaluated in `CNT_W+1` bits.
- A send and a return in the same cycle leave the count unchanged.
- When `credit_cnt == 0`, `data_in_rdy` is 0. A `credit_ret` in that cycle makes the count 1 the following cycle, so the credit is usable one cycle after it arrives. There is no bypass.

Overflow:
- Overflow is `credit_ret` arriving while `credit_cnt == CREDITS` with no `send` in the same cycle.
- On overflow, `credit_err` sets and stays set until reset or `init`, and the count saturates at `CREDITS`.
- Underflow cannot occur by construction. The verification engineer must assert this.

Status FSM (2 bits, drives only `idle` and the assertions):
- States are `RUN`, `STARVED` and `FAULT`.
- `RUN` goes to `STARVED` when the next count is 0.
- `STARVED` goes to `RUN` when the next count is greater than 0.
- Any state goes to `FAULT` on overflow.
- `FAULT` is left only by reset or `init`, which return the FSM to `RUN`.
- In `FAULT`, sending continues using the saturated count.

Reset and `init`:
- Both give `credit_cnt = CREDITS`, `tx_val = 0`, `tx_data = 0`, `credit_err = 0`, FSM `RUN`, `data_in_rdy = 1` and `idle = 1`.
- A word launched in the cycle before reset still appears on `tx_val` in that cycle. The link partner must be reset or init'ed together with this block.

## Timing
- Latency from `data_in` to `tx_data` is 1 cycle.
- The credit-count update latency is 1 cycle.
- Throughput is 1 word per cycle while credits are nonzero.
- Sustained full rate requires `CREDITS` to be at least the round-trip latency, measured from `tx_val` through the remote pop to `credit_ret` plus 1. Below that, throughput is `CREDITS / RTT`.
- `data_in_rdy`, `idle` and `credit_err` are glitch-free register decodes.
- `credit_ret` is assumed to be already synchronous to `clk`.

## Structure
- A shared package `credit_pkg` holds the FSM typedef `credit_state_e` (`RUN`, `STARVED`, `FAULT`) and the width function `cnt_w(credits)`. The future receive-side `credit_rx` reuses both.
- One sub-module, `sat_updown_cnt`, is parameterised by width and maximum. It has `inc`/`dec`/`load` inputs and `cnt`/`ovf` outputs.
- Everything else (data register, FSM, decodes) lives in `credit_tx`.

## Test plan
- **Reset:** hold `arst_n = 0` for 2 cycles, then release. Expect `credit_cnt = 5`, `data_in_rdy = 1`, `tx_val = 0`, `idle = 1`, `credit_err = 0`.
- **Exhaust credits:** hold `data_in_val` high with data 0xA0..0xA6 and no returns. Expect 0xA0..0xA4 on `tx_data` on consecutive cycles, each 1 cycle after acceptance. `data_in_rdy` falls after the 5th accept, `credit_cnt = 0`, FSM `STARVED`.
- **Return from zero:** with `credit_cnt = 0`, pulse `credit_ret` for 1 cycle while `data_in_val` is high. Expect no accept in the pulse cycle, count = 1 the next cycle, then accept 0xA5, then the count returns to 0.
- **Simultaneous:** with `credit_cnt = 3`, assert `send` and `credit_ret` for 10 cycles. Expect the count stays 3 and 10 words go out back to back.
- **Overflow:** with `credit_cnt = 5`, pulse `credit_ret` with no send. Expect `credit_err = 1`, count stays 5, `idle = 0`, the error persists until `init`, and `init` restores the full reset values.
- **Closed loop:** connect to `pipeline_fifo` with `FIFO_DEPTH = 5` and a 3-cycle `credit_ret` delay on pop, with random `data_out_rdy`, for 10k words. Expect no loss or reorder, `credit_err = 0`, and the remote FIFO is never full while `tx_val` is high.

Source files
------------

// File: rtl/credit_pkg.sv
// Types and helpers shared by the transmit and receive ends of the credit link.
package credit_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STARVED = 2'd1,
        FAULT   = 2'd2
    } credit_state_e;

    // Counter width needed to hold every value from 0 up to and including credits.
    function automatic int cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Up/down counter that saturates at MAX and flags any increment past MAX.
module sat_updown_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 5
) (
    input  logic             clk,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   sum;

    // One extra bit so the sum can exceed MAX without wrapping before the check.
    always_comb begin
        sum   = {1'b0, cnt_q} + {{WIDTH{1'b0}}, inc} - {{WIDTH{1'b0}}, dec};
        ovf   = !load && (sum > MAX_X);
        cnt_d = ovf ? MAX_W : sum[WIDTH-1:0];
        if (load) begin
            cnt_d = MAX_W;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/credit_tx.sv
// Transmit end of a credit-based link: registered ready-less valid/data out,
// credits mirror free slots in the remote FIFO and come back one per pop.
module credit_tx
    import credit_pkg::*;
#(
    parameter int ELEM_WIDTH = 32,
    parameter int CREDITS    = 5,
    parameter int CNT_W      = cnt_w(CREDITS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  init,
    input  logic [ELEM_WIDTH-1:0] data_in,
    input  logic                  data_in_val,
    output logic                  data_in_rdy,
    output logic [ELEM_WIDTH-1:0] tx_data,
    output logic                  tx_val,
    input  logic                  credit_ret,
    output logic [CNT_W-1:0]      credit_cnt,
    output logic                  credit_err,
    output logic                  idle,
    output logic [1:0]            dbg_state
);

    // Handshake: data_in is taken in any cycle where data_in_val && data_in_rdy;
    // data_in_rdy depends on the credit register only. tx_val has no ready and
    // the receiver takes every word it qualifies.

    logic                  load;
    logic                  send;
    logic                  ovf;
    logic [CNT_W:0]        cnt_nx;
    logic                  tx_val_q;
    logic [ELEM_WIDTH-1:0] tx_data_q;
    logic                  err_q;
    credit_state_e         state_q;

    assign load        = !arst_n || init;
    assign data_in_rdy = (credit_cnt != '0);
    assign send        = data_in_val && data_in_rdy;
    assign cnt_nx      = {1'b0, credit_cnt} - (CNT_W + 1)'(send) + (CNT_W + 1)'(credit_ret);

    sat_updown_cnt #(
        .WIDTH (CNT_W),
        .MAX   (CREDITS)
    ) u_cnt (
        .clk  (clk),
        .load (load),
        .inc  (credit_ret),
        .dec  (send),
        .cnt  (credit_cnt),
        .ovf  (ovf)
    );

    always_ff @(posedge clk) begin
        if (load) begin
            tx_val_q  <= 1'b0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            state_q   <= RUN;
        end else begin
            tx_val_q <= send;
            if (send) begin
                tx_data_q <= data_in;
            end
            if (ovf) begin
                err_q <= 1'b1;
            end
            case (state_q)
                RUN:     if (ovf) state_q <= FAULT;
                         else if (cnt_nx == '0) state_q <= STARVED;
                STARVED: if (ovf) state_q <= FAULT;
                         else if (cnt_nx != '0) state_q <= RUN;
                default: state_q <= FAULT;
            endcase
        end
    end

    assign tx_val     = tx_val_q;
    assign tx_data    = tx_data_q;
    assign credit_err = err_q;
    assign idle       = (credit_cnt == CNT_W'(CREDITS)) && !tx_val_q && !err_q;
    assign dbg_state  = state_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
        !(send && credit_cnt == '0));
    a_cnt_in_range: assert property (@(posedge clk) disable iff (!arst_n)
        credit_cnt <= CNT_W'(CREDITS));
    a_starved_iff_zero: assert property (@(posedge clk) disable iff (!arst_n || init)
        (state_q != FAULT) |-> ((state_q == STARVED) == (credit_cnt == '0)));

endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx: directed credit scenarios plus a closed loop against a
// behavioural remote FIFO with delayed credit return.
module tb_credit_tx;
  import credit_pkg::*;

  localparam int W = 32;
  localparam int CR = 5;
  localparam int CW = cnt_w(CR);
  localparam int N_LOOP = 10000;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic init = 1'b0;
  logic [W-1:0] data_in = '0;
  logic data_in_val = 1'b0;
  logic data_in_rdy;
  logic [W-1:0] tx_data;
  logic tx_val;
  logic credit_ret;
  logic dir_ret = 1'b0;
  logic [CW-1:0] credit_cnt;
  logic credit_err;
  logic idle;
  logic [1:0] dbg_state;

  logic loop_en = 1'b0;
  logic [2:0] ret_pipe = '0;
  logic [W-1:0] rq[$];
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  assign credit_ret = loop_en ? ret_pipe[2] : dir_ret;

  credit_tx #(.ELEM_WIDTH(W), .CREDITS(CR)) dut (
    .clk(clk), .arst_n(arst_n), .init(init),
    .data_in(data_in), .data_in_val(data_in_val), .data_in_rdy(data_in_rdy),
    .tx_data(tx_data), .tx_val(tx_val), .credit_ret(credit_ret),
    .credit_cnt(credit_cnt), .credit_err(credit_err), .idle(idle),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called on a negedge, applies one cycle of inputs, returns on the next negedge
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic exp_rdy);
    check("data_in_rdy", data_in_rdy, exp_rdy);
    data_in_val = v;
    data_in = d;
    dir_ret = r;
    if (v && exp_rdy) exp_q.push_back(d);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (arst_n && tx_val) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", tx_data, 32'hDEAD_BEEF);
        errors = errors;
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  // remote FIFO: pop first, then take the incoming word; a pop returns a credit 3 cycles later
  always @(negedge clk) begin
    logic popped;
    popped = 1'b0;
    if (loop_en) begin
      if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
        void'(rq.pop_front());
        popped = 1'b1;
      end
      if (tx_val) begin
        check("rfifo_space", W'(rq.size() < CR), 1);
        rq.push_back(tx_data);
      end
      ret_pipe = {ret_pipe[1:0], popped};
    end
  end

  initial begin
    int sent;
    int cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // reset values
    check("rst_cnt", credit_cnt, 5);
    check("rst_rdy", data_in_rdy, 1);
    check("rst_tx_val", tx_val, 0);
    check("rst_idle", idle, 1);
    check("rst_err", credit_err, 0);
    check("rst_state", dbg_state, RUN);

    // exhaust credits with 0xA0..0xA6; only 0xA0..0xA4 get through
    for (int k = 0; k < 7; k++) begin
      check("exh_cnt", credit_cnt, (k < 5) ? 5 - k : 0);
      if (k >= 1 && k <= 5) check("exh_tx_val", tx_val, 1);
      drive(1'b1, 32'hA0 + k, 1'b0, k < 5);
    end
    check("exh_cnt_end", credit_cnt, 0);
    check("exh_state", dbg_state, STARVED);
    check("exh_tx_val_end", tx_val, 0);

    // return from zero: no bypass in the return cycle
    drive(1'b1, 32'hA5, 1'b1, 1'b0);
    check("rz_cnt1", credit_cnt, 1);
    check("rz_state", dbg_state, RUN);
    drive(1'b1, 32'hA5, 1'b0, 1'b1);
    check("rz_cnt0", credit_cnt, 0);
    check("rz_tx_val", tx_val, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // climb to 3 credits, then send and return together for 10 cycles
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("sim_cnt_start", credit_cnt, 3);
    for (int i = 0; i < 10; i++) begin
      check("sim_cnt", credit_cnt, 3);
      if (i > 0) check("sim_tx_val", tx_val, 1);
      drive(1'b1, 32'hB0 + i, 1'b1, 1'b1);
    end
    check("sim_cnt_end", credit_cnt, 3);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("full_cnt", credit_cnt, 5);
    check("full_idle", idle, 1);

    // overflow: return with no send at full count
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("ovf_cnt", credit_cnt, 5);
    check("ovf_err", credit_err, 1);
    check("ovf_idle", idle, 0);
    check("ovf_state", dbg_state, FAULT);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_sticky", credit_err, 1);
    drive(1'b1, 32'hC0, 1'b0, 1'b1);
    check("fault_send_cnt", credit_cnt, 4);
    check("fault_state", dbg_state, FAULT);
    check("fault_err", credit_err, 1);

    // init wins over a concurrent send
    init = 1'b1;
    data_in_val = 1'b1;
    data_in = 32'hD0;
    @(negedge clk);
    init = 1'b0;
    data_in_val = 1'b0;
    check("init_cnt", credit_cnt, 5);
    check("init_err", credit_err, 0);
    check("init_idle", idle, 1);
    check("init_tx_val", tx_val, 0);
    check("init_tx_data", tx_data, 0);
    check("init_rdy", data_in_rdy, 1);
    check("init_state", dbg_state, RUN);

    // closed loop
    loop_en = 1'b1;
    sent = 0;
    cyc = 0;
    while (sent < N_LOOP && cyc < 60000) begin
      data_in_val = ($urandom_range(0, 3) != 0);
      data_in = $urandom;
      if (data_in_val && data_in_rdy) begin
        exp_q.push_back(data_in);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    data_in_val = 1'b0;
    check("loop_sent", sent, N_LOOP);
    cyc = 0;
    while (!(credit_cnt == CR && rq.size() == 0 && !tx_val) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("loop_drain_cnt", credit_cnt, 5);
    check("loop_err", credit_err, 0);
    check("loop_idle", idle, 1);
    check("loop_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
